// File: rtl/inst_loader.sv
// Loads a little-endian byte stream (word count N, then N words) into the instruction RAM and holds the core until it is written.
// Each write strobe follows a word's 4th byte by one cycle; rx_ready stays high in CNT/DATA, so bytes are taken back-to-back.
module inst_loader #(
    parameter int             w         = 32,
    parameter int             h         = 8,
    parameter logic [w-1:0]   BASE_ADDR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_err
);

    typedef enum logic [2:0] {IDLE, CNT, DATA, DONE, ERR} state_t;

    localparam logic [31:0] CAP = 32'd1 << h;

    state_t         state_q, state_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [h:0]     word_cnt_q, word_cnt_d;
    logic [31:0]    shift_q, shift_d;
    logic [31:0]    n_q, n_d;
    logic           wr_pend_q, wr_pend_d;
    logic           is_write_q, is_write_d;
    logic [w-1:0]   im_addr_q, im_addr_d;
    logic [w-1:0]   im_inst_q, im_inst_d;
    logic           rx_ready_q, rx_ready_d;
    logic           core_hold_q, core_hold_d;
    logic           load_done_q, load_done_d;
    logic           load_err_q, load_err_d;

    logic           accept;
    logic [31:0]    word_full;
    logic           released;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        n_d        = n_q;
        wr_pend_d  = 1'b0;
        is_write_d = 1'b0;
        im_addr_d  = im_addr_q;
        im_inst_d  = im_inst_q;
        accept     = rx_valid && rx_ready_q;
        word_full  = {rx_data, shift_q[31:8]};

        // shift_q still holds the completed word here; the next byte only lands on this same edge.
        if (wr_pend_q) begin
            is_write_d = 1'b1;
            im_addr_d  = BASE_ADDR + (w'(word_cnt_q) << 2);
            im_inst_d  = w'(shift_q);
            word_cnt_d = word_cnt_q + {{h{1'b0}}, 1'b1};
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = CNT;
                    byte_cnt_d = 2'd0;
                end
            end
            CNT: begin
                if (accept) begin
                    shift_d    = word_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        n_d = word_full;
                        if (word_full == 32'd0) begin
                            state_d = DONE;
                        end else if (word_full > CAP) begin
                            state_d = ERR;
                        end else begin
                            state_d    = DATA;
                            word_cnt_d = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d    = word_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_pend_d = 1'b1;
                        if (32'(word_cnt_q) == n_q - 32'd1) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Release only once DONE has no write still in flight, and drop it again on a restart.
        released    = (state_q == DONE) && (state_d == DONE) && !wr_pend_q;
        rx_ready_d  = (state_d == CNT) || (state_d == DATA);
        core_hold_d = !released;
        load_done_d = released;
        load_err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            n_q         <= '0;
            wr_pend_q   <= 1'b0;
            is_write_q  <= 1'b0;
            im_addr_q   <= '0;
            im_inst_q   <= '0;
            rx_ready_q  <= 1'b0;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            wr_pend_q   <= wr_pend_d;
            is_write_q  <= is_write_d;
            im_addr_q   <= im_addr_d;
            im_inst_q   <= im_inst_d;
            rx_ready_q  <= rx_ready_d;
            core_hold_q <= core_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign is_write  = is_write_q;
    assign im_addr   = im_addr_q;
    assign im_inst   = im_inst_q;
    assign core_hold = core_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: streams hand-built images and checks the RAM writes and status outputs.
module tb_inst_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        is_write;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wacc[$];
    logic        wh[$];
    int          acc = 0;

    inst_loader #(.w(32), .h(8), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .is_write  (is_write),
        .im_addr   (im_addr),
        .im_inst   (im_inst),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logs every write strobe with the number of bytes accepted before it and the core_hold level.
    always @(negedge clk) begin
        if (is_write) begin
            wa.push_back(im_addr);
            wd.push_back(im_inst);
            wacc.push_back(acc);
            wh.push_back(core_hold);
        end
        if (rx_valid && rx_ready) acc = acc + 1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i < wd.size()) ? wd[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] qacc(input int i);
        return (i < wacc.size()) ? 32'(wacc[i]) : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] qh(input int i);
        return (i < wh.size()) ? 32'(wh[i]) : 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rdy_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        if (gap) begin
            rx_valid = 1'b0;
            tick(1);
        end
    endtask

    task automatic send_word(input logic [31:0] v, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_is_write"},  32'(is_write),  32'd0);
        chk({pfx, "_im_addr"},   im_addr,        32'd0);
        chk({pfx, "_im_inst"},   im_inst,        32'd0);
        chk({pfx, "_rx_ready"},  32'(rx_ready),  32'd0);
        chk({pfx, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({pfx, "_load_done"}, 32'(load_done), 32'd0);
        chk({pfx, "_load_err"},  32'(load_err),  32'd0);
    endtask

    initial begin
        int wb;
        int ab;
        int bad;

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(1);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Two-word image, bytes back-to-back.
        wb = wa.size();
        ab = acc;
        pulse_start();
        chk("t1_cnt_rx_ready", 32'(rx_ready), 32'd1);
        send_word(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        rx_valid = 1'b0;
        tick(3);
        chk("t1_nwrites",   32'(wa.size() - wb), 32'd2);
        chk("t1_addr0",     qa(wb),     32'h0);
        chk("t1_data0",     qd(wb),     32'h1234_5678);
        chk("t1_addr1",     qa(wb + 1), 32'h4);
        chk("t1_data1",     qd(wb + 1), 32'hDEAD_BEEF);
        chk("t1_acc0",      qacc(wb) - 32'(ab),     32'd9);
        chk("t1_acc1",      qacc(wb + 1) - 32'(ab), 32'd12);
        chk("t1_hold_at_last_wr", qh(wb + 1), 32'd1);
        chk("t1_load_done", 32'(load_done), 32'd1);
        chk("t1_core_hold", 32'(core_hold), 32'd0);
        chk("t1_rx_ready",  32'(rx_ready),  32'd0);

        // Same image with rx_valid toggling every other cycle.
        wb = wa.size();
        ab = acc;
        pulse_start();
        chk("t2_done_cleared", 32'(load_done), 32'd0);
        chk("t2_hold_set",     32'(core_hold), 32'd1);
        send_word(32'd2, 1'b1);
        send_word(32'h1234_5678, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        tick(3);
        chk("t2_nwrites", 32'(wa.size() - wb), 32'd2);
        chk("t2_addr0",   qa(wb),     32'h0);
        chk("t2_data0",   qd(wb),     32'h1234_5678);
        chk("t2_addr1",   qa(wb + 1), 32'h4);
        chk("t2_data1",   qd(wb + 1), 32'hDEAD_BEEF);
        chk("t2_acc0",    qacc(wb) - 32'(ab),     32'd8);
        chk("t2_acc1",    qacc(wb + 1) - 32'(ab), 32'd12);
        chk("t2_load_done", 32'(load_done), 32'd1);

        // Empty image.
        wb = wa.size();
        pulse_start();
        send_word(32'd0, 1'b0);
        rx_valid = 1'b0;
        tick(2);
        chk("t3_nwrites",   32'(wa.size() - wb), 32'd0);
        chk("t3_load_done", 32'(load_done), 32'd1);
        chk("t3_core_hold", 32'(core_hold), 32'd0);
        chk("t3_rx_ready",  32'(rx_ready),  32'd0);

        // Oversized image (N=257), then recovery with a one-word image.
        wb = wa.size();
        pulse_start();
        send_word(32'd257, 1'b0);
        rx_valid = 1'b0;
        chk("t4_load_err",  32'(load_err),  32'd1);
        chk("t4_rx_ready",  32'(rx_ready),  32'd0);
        chk("t4_core_hold", 32'(core_hold), 32'd1);
        tick(3);
        chk("t4_nwrites",   32'(wa.size() - wb), 32'd0);
        chk("t4_load_done", 32'(load_done), 32'd0);
        pulse_start();
        chk("t4_err_cleared", 32'(load_err), 32'd0);
        send_word(32'd1, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0);
        rx_valid = 1'b0;
        tick(3);
        chk("t4_rec_nwrites", 32'(wa.size() - wb), 32'd1);
        chk("t4_rec_addr",    qa(wb), 32'h0);
        chk("t4_rec_data",    qd(wb), 32'hDDCC_BBAA);
        chk("t4_rec_done",    32'(load_done), 32'd1);

        // Full-capacity image (N=256).
        wb = wa.size();
        pulse_start();
        send_word(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'hA500_0000 | 32'(i * 3), 1'b0);
        rx_valid = 1'b0;
        tick(3);
        chk("t5_nwrites", 32'(wa.size() - wb), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (qa(wb + i) !== 32'(4 * i) || qd(wb + i) !== (32'hA500_0000 | 32'(i * 3))) bad++;
        end
        chk("t5_bad_words", 32'(bad), 32'd0);
        chk("t5_last_addr", qa(wb + 255), 32'h3FC);
        chk("t5_load_done", 32'(load_done), 32'd1);
        chk("t5_core_hold", 32'(core_hold), 32'd0);

        // Reset after six data bytes, then a fresh load from the count phase.
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        tick(1);
        check_reset_outputs("t6");
        rst_n = 1'b1;
        tick(1);
        wb = wa.size();
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        rx_valid = 1'b0;
        tick(3);
        chk("t6_nwrites", 32'(wa.size() - wb), 32'd1);
        chk("t6_addr",    qa(wb), 32'h0);
        chk("t6_data",    qd(wb), 32'h1122_3344);
        chk("t6_done",    32'(load_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
